// File: rtl/ahb_bus_arbiter_if.sv
// Signal bundle shared by two AHB-Lite masters, the slave-side bus and the arbiter.
// The arbiter connects through the slave modport; the bench drives the master modport.
interface ahb_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_hbusreq, m1_hbusreq;
  logic                  m0_hlock, m1_hlock;
  logic [1:0]            m0_htrans, m1_htrans;
  logic [ADDR_WIDTH-1:0] m0_haddr, m1_haddr;
  logic                  m0_hwrite, m1_hwrite;
  logic [2:0]            m0_hsize, m1_hsize;
  logic [2:0]            m0_hburst, m1_hburst;
  logic [DATA_WIDTH-1:0] m0_hwdata, m1_hwdata;
  logic                  m0_hgrant, m1_hgrant;
  logic                  m0_hready, m1_hready;
  logic [DATA_WIDTH-1:0] m0_hrdata, m1_hrdata;
  logic                  m0_hresp, m1_hresp;

  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HRESP;

  modport slave (
    input  m0_hbusreq, m0_hlock, m0_htrans, m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hwdata,
    input  m1_hbusreq, m1_hlock, m1_htrans, m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hwdata,
    output m0_hgrant, m0_hready, m0_hrdata, m0_hresp,
    output m1_hgrant, m1_hready, m1_hrdata, m1_hresp,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HMASTLOCK,
    input  HREADY, HRDATA, HRESP
  );

  modport master (
    output m0_hbusreq, m0_hlock, m0_htrans, m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hwdata,
    output m1_hbusreq, m1_hlock, m1_htrans, m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hwdata,
    input  m0_hgrant, m0_hready, m0_hrdata, m0_hresp,
    input  m1_hgrant, m1_hready, m1_hrdata, m1_hresp,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HMASTLOCK,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Two-master round-robin AHB-Lite arbiter: address-phase owner FSM, separate data-phase
// owner, beat-limited tenure, and bus/response routing between M0, M1 and the shared slave.
module ahb_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  ahb_bus_arbiter_if.slave    bus
);
  localparam int             CW        = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]  BEAT_MAX  = CW'(MAX_BEATS);
  localparam logic [1:0]     TR_IDLE   = 2'd0;
  localparam logic [1:0]     TR_NONSEQ = 2'd2;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN0 = 2'd1, ST_OWN1 = 2'd2} state_t;
  typedef enum logic [1:0] {DO_NONE = 2'd0, DO_M0 = 2'd1, DO_M1 = 2'd2} downer_t;

  state_t        r_state, w_state_nxt;
  downer_t       r_downer, w_downer_nxt;
  logic          r_rr, w_rr_nxt;
  logic [CW-1:0] r_beats, w_beats_nxt, w_beats_inc;
  logic          r_grant0, r_grant1;
  logic          w_own_req, w_oth_req, w_own_lock, w_xfer, w_quiet, w_permit;
  logic [1:0]    w_own_trans;

  // Address-phase mux: the current owner drives the bus, nobody means an idle bus.
  always_comb begin
    bus.HADDR     = {ADDR_WIDTH{1'b0}};
    bus.HTRANS    = TR_IDLE;
    bus.HWRITE    = 1'b0;
    bus.HSIZE     = 3'd0;
    bus.HBURST    = 3'd0;
    bus.HMASTLOCK = 1'b0;
    case (r_state)
      ST_OWN0: begin
        bus.HADDR     = bus.m0_haddr;
        bus.HTRANS    = bus.m0_htrans;
        bus.HWRITE    = bus.m0_hwrite;
        bus.HSIZE     = bus.m0_hsize;
        bus.HBURST    = bus.m0_hburst;
        bus.HMASTLOCK = bus.m0_hlock;
      end
      ST_OWN1: begin
        bus.HADDR     = bus.m1_haddr;
        bus.HTRANS    = bus.m1_htrans;
        bus.HWRITE    = bus.m1_hwrite;
        bus.HSIZE     = bus.m1_hsize;
        bus.HBURST    = bus.m1_hburst;
        bus.HMASTLOCK = bus.m1_hlock;
      end
      default: bus.HTRANS = TR_IDLE;
    endcase
  end

  // Write data follows the data-phase owner, which may lag the address owner by one transfer.
  always_comb begin
    case (r_downer)
      DO_M0:   bus.HWDATA = bus.m0_hwdata;
      DO_M1:   bus.HWDATA = bus.m1_hwdata;
      default: bus.HWDATA = {DATA_WIDTH{1'b0}};
    endcase
  end

  // A non-owner presenting a transfer is stalled; an idle non-owner sees ready.
  assign bus.m0_hready = (r_downer == DO_M0 || r_state == ST_OWN0) ? bus.HREADY
                                                                   : (bus.m0_htrans == TR_IDLE);
  assign bus.m1_hready = (r_downer == DO_M1 || r_state == ST_OWN1) ? bus.HREADY
                                                                   : (bus.m1_htrans == TR_IDLE);
  assign bus.m0_hrdata = bus.HRDATA;
  assign bus.m1_hrdata = bus.HRDATA;
  assign bus.m0_hresp  = bus.HRESP;
  assign bus.m1_hresp  = bus.HRESP;
  assign bus.m0_hgrant = r_grant0;
  assign bus.m1_hgrant = r_grant1;

  always_comb begin
    w_own_req   = 1'b0;
    w_oth_req   = 1'b0;
    w_own_lock  = 1'b0;
    w_own_trans = TR_IDLE;
    case (r_state)
      ST_OWN0: begin
        w_own_req   = bus.m0_hbusreq;
        w_oth_req   = bus.m1_hbusreq;
        w_own_lock  = bus.m0_hlock;
        w_own_trans = bus.m0_htrans;
      end
      ST_OWN1: begin
        w_own_req   = bus.m1_hbusreq;
        w_oth_req   = bus.m0_hbusreq;
        w_own_lock  = bus.m1_hlock;
        w_own_trans = bus.m1_htrans;
      end
      default: w_own_trans = TR_IDLE;
    endcase
    w_xfer      = (r_state != ST_IDLE) && w_own_trans[1];
    // The beat accepted at this edge counts toward the limit, so tenure ends after exactly MAX_BEATS.
    w_beats_inc = (w_xfer && (r_beats != BEAT_MAX)) ? r_beats + {{(CW-1){1'b0}}, 1'b1} : r_beats;
    w_quiet     = ((w_own_trans == TR_IDLE) || (w_own_trans == TR_NONSEQ)) && !w_own_lock;
    w_permit    = (r_state == ST_IDLE) || (w_quiet && !w_own_req) ||
                  (w_quiet && w_oth_req && (w_beats_inc >= BEAT_MAX));
  end

  // Next owner selection; HREADY low freezes every piece of arbitration state.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr;
    w_downer_nxt = r_downer;
    w_beats_nxt  = r_beats;
    if (bus.HREADY) begin
      if (w_permit) begin
        case ({bus.m1_hbusreq, bus.m0_hbusreq})
          2'b01: begin w_state_nxt = ST_OWN0; w_rr_nxt = 1'b1; end
          2'b10: begin w_state_nxt = ST_OWN1; w_rr_nxt = 1'b0; end
          2'b11: begin
            if (r_rr) begin
              w_state_nxt = ST_OWN1;
              w_rr_nxt    = 1'b0;
            end else begin
              w_state_nxt = ST_OWN0;
              w_rr_nxt    = 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end else begin
        w_state_nxt = r_state;
      end
      if (w_xfer) begin
        w_downer_nxt = (r_state == ST_OWN1) ? DO_M1 : DO_M0;
      end else begin
        w_downer_nxt = DO_NONE;
      end
      w_beats_nxt = (w_state_nxt != r_state) ? {CW{1'b0}} : w_beats_inc;
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_downer <= DO_NONE;
      r_rr     <= 1'b0;
      r_beats  <= {CW{1'b0}};
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_downer <= w_downer_nxt;
      r_rr     <= w_rr_nxt;
      r_beats  <= w_beats_nxt;
      r_grant0 <= (w_state_nxt == ST_OWN0);
      r_grant1 <= (w_state_nxt == ST_OWN1);
    end
  end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Randomized scoreboard bench for ahb_bus_arbiter: an ownership-level reference model
// predicts every bus/master output each cycle; a monitor pops and compares them.
module tb_ahb_bus_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MAXB    = 4;
  localparam int NCYC    = 4000;
  localparam int RST_CYC = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ahb_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus.slave)
  );

  typedef struct packed {
    logic [1:0]    htrans;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic          hmastlock;
    logic [1:0]    grant;
    logic [1:0]    hready;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, passed = 0, pushed = 0, popped = 0;

  logic          mreq[2], mlock[2], mwrite[2];
  logic [1:0]    mtrans[2];
  logic [AW-1:0] maddr[2];
  logic [2:0]    msize[2], mburst[2];
  logic [DW-1:0] mwdata[2];
  logic          s_hready, s_hresp;
  logic [DW-1:0] s_hrdata;
  int            burst_left[2], lock_left[2];
  bit            regen;
  int            own, dow, rr, beats;

  assign bus.m0_hbusreq = mreq[0];   assign bus.m1_hbusreq = mreq[1];
  assign bus.m0_hlock   = mlock[0];  assign bus.m1_hlock   = mlock[1];
  assign bus.m0_htrans  = mtrans[0]; assign bus.m1_htrans  = mtrans[1];
  assign bus.m0_haddr   = maddr[0];  assign bus.m1_haddr   = maddr[1];
  assign bus.m0_hwrite  = mwrite[0]; assign bus.m1_hwrite  = mwrite[1];
  assign bus.m0_hsize   = msize[0];  assign bus.m1_hsize   = msize[1];
  assign bus.m0_hburst  = mburst[0]; assign bus.m1_hburst  = mburst[1];
  assign bus.m0_hwdata  = mwdata[0]; assign bus.m1_hwdata  = mwdata[1];
  assign bus.HREADY     = s_hready;
  assign bus.HRDATA     = s_hrdata;
  assign bus.HRESP      = s_hresp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
  endtask

  function automatic void model_reset();
    own = -1; dow = -1; rr = 0; beats = 0; regen = 1'b1;
    for (int n = 0; n < 2; n++) begin
      burst_left[n] = 0;
      lock_left[n]  = 0;
    end
  endfunction

  // Expected outputs from the ownership view: who owns the address, who owns the data.
  function automatic exp_t model_outputs();
    exp_t e;
    e = '0;
    if (own >= 0) begin
      e.htrans    = mtrans[own];
      e.haddr     = maddr[own];
      e.hwrite    = mwrite[own];
      e.hsize     = msize[own];
      e.hburst    = mburst[own];
      e.hmastlock = mlock[own];
    end
    if (dow >= 0) e.hwdata = mwdata[dow];
    for (int n = 0; n < 2; n++) begin
      e.grant[n]  = (own == n);
      e.hready[n] = (dow == n || own == n) ? s_hready : (mtrans[n] == 2'd0);
      e.resp[n]   = s_hresp;
    end
    e.rdata = s_hrdata;
    return e;
  endfunction

  // Reference arbitration rules applied at a rising edge.
  function automatic void model_step();
    int  nown, cnt, other;
    bit  xfer, quiet, permit;
    regen = s_hready;
    if (!s_hready) return;
    xfer = (own >= 0) && (mtrans[own] >= 2'd2);
    if (xfer) begin
      if (mtrans[own] == 2'd3 && burst_left[own] > 0) burst_left[own]--;
      if (lock_left[own] > 0) lock_left[own]--;
    end
    cnt = beats + (xfer ? 1 : 0);
    if (cnt > MAXB) cnt = MAXB;
    other  = (own == 1) ? 0 : 1;
    quiet  = (own >= 0) && (mtrans[own] == 2'd0 || mtrans[own] == 2'd2) && !mlock[own];
    permit = (own < 0) || (quiet && !mreq[own]) || (quiet && cnt >= MAXB && mreq[other]);
    nown = own;
    if (permit) begin
      if (mreq[0] && mreq[1]) nown = rr;
      else if (mreq[0])       nown = 0;
      else if (mreq[1])       nown = 1;
      else                    nown = -1;
      if (nown >= 0) rr = 1 - nown;
    end
    dow   = xfer ? own : -1;
    beats = (nown != own) ? 0 : cnt;
    own   = nown;
  endfunction

  // Masters change their request only after an HREADY=1 edge; bursts of INCR4 and locked runs mixed in.
  task automatic drive_inputs();
    int  r;
    bit  granted;
    for (int n = 0; n < 2; n++) begin
      if (regen) begin
        granted = (own == n);
        if (!granted) begin
          burst_left[n] = 0;
          lock_left[n]  = 0;
        end
        if (granted && burst_left[n] > 0) begin
          if ($urandom_range(0, 7) == 0) mtrans[n] = 2'd1;
          else begin
            mtrans[n] = 2'd3;
            maddr[n]  = maddr[n] + 32'd4;
          end
        end else begin
          r = $urandom_range(0, 3);
          mburst[n] = 3'd0;
          if (granted) begin
            mtrans[n] = (r == 0) ? 2'd0 : 2'd2;
            if (r == 2) begin
              mburst[n]     = 3'd3;
              burst_left[n] = 3;
            end
          end else begin
            mtrans[n] = (r[0]) ? 2'd2 : 2'd0;
          end
          maddr[n]  = $urandom;
          mwrite[n] = ($urandom_range(0, 1) == 1);
          msize[n]  = 3'd2;
        end
        if (granted && lock_left[n] == 0 && $urandom_range(0, 15) == 0)
          lock_left[n] = $urandom_range(2, 6);
        mlock[n]  = (lock_left[n] > 0);
        mreq[n]   = (burst_left[n] > 0 || lock_left[n] > 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        mwdata[n] = $urandom;
      end
    end
    s_hready = ($urandom_range(0, 3) != 0);
    s_hrdata = $urandom;
    s_hresp  = ($urandom_range(0, 9) == 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_HTRANS"},    bus.HTRANS, 64'd0);
    check({tag, "_HADDR"},     bus.HADDR, 64'd0);
    check({tag, "_HWDATA"},    bus.HWDATA, 64'd0);
    check({tag, "_HWRITE"},    bus.HWRITE, 64'd0);
    check({tag, "_HMASTLOCK"}, bus.HMASTLOCK, 64'd0);
    check({tag, "_m0_hgrant"}, bus.m0_hgrant, 64'd0);
    check({tag, "_m1_hgrant"}, bus.m1_hgrant, 64'd0);
  endtask

  // Monitor: compares whatever expectation the stimulus side queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        popped++;
        check("HTRANS",    bus.HTRANS, e.htrans);
        check("HADDR",     bus.HADDR, e.haddr);
        check("HWRITE",    bus.HWRITE, e.hwrite);
        check("HSIZE",     bus.HSIZE, e.hsize);
        check("HBURST",    bus.HBURST, e.hburst);
        check("HWDATA",    bus.HWDATA, e.hwdata);
        check("HMASTLOCK", bus.HMASTLOCK, e.hmastlock);
        check("hgrant",    {bus.m1_hgrant, bus.m0_hgrant}, e.grant);
        check("hready",    {bus.m1_hready, bus.m0_hready}, e.hready);
        check("m0_hrdata", bus.m0_hrdata, e.rdata);
        check("m1_hrdata", bus.m1_hrdata, e.rdata);
        check("hresp",     {bus.m1_hresp, bus.m0_hresp}, e.resp);
      end
    end
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      mreq[n] = 1'b0; mlock[n] = 1'b0; mtrans[n] = 2'd0; maddr[n] = '0;
      mwrite[n] = 1'b0; msize[n] = 3'd0; mburst[n] = 3'd0; mwdata[n] = '0;
    end
    s_hready = 1'b1; s_hrdata = '0; s_hresp = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc == 0 || cyc == RST_CYC) begin
        rst_n = 1'b0;
        #1;
        reset_checks((cyc == 0) ? "reset" : "midreset");
        model_reset();
      end else begin
        rst_n = 1'b1;
        drive_inputs();
        #1;
        sb_q.push_back(model_outputs());
        pushed++;
        @(posedge clk);
        model_step();
      end
    end
    @(negedge clk);
    #3;
    check("sb_drain", popped, pushed);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Two-master arbiter that shares the single AHB-Lite slave-side bus (decoder, mux, memory controller) between requesters M0 and M1. It owns address-phase ownership through a 3-state FSM and tracks data-phase ownership separately. It multiplexes master address/control and write data onto the bus, and routes HREADY/HRDATA/HRESP back to the correct master. Arbitration is round-robin, never breaks a burst or locked sequence, and bounds tenure with a beat limit.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MAX_BEATS, 16, accepted transfers before forced handover when the other master requests (≥1)
- HCLK  in  1  bus clock, rising edge
- HRESETn  in  1  reset; one clock, asynchronous assert, active-low
- mN_hbusreq  in  1  master N request (N = 0, 1; likewise below)
- mN_hlock  in  1  master N locked-sequence request
- mN_htrans  in  2  master N HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- mN_haddr  in  ADDR_WIDTH  master N address
- mN_hwrite / mN_hsize / mN_hburst  in  1/3/3  master N control
- mN_hwdata  in  DATA_WIDTH  master N write data
- mN_hgrant  out  1  master N owns address phase (registered)
- mN_hready  out  1  master N HREADY
- mN_hrdata  out  DATA_WIDTH  master N read data
- mN_hresp  out  1  master N response
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA  out  bus address/control/write data
- HMASTLOCK  out  1  owner's hlock
- HREADY, HRDATA, HRESP  in  bus slave-side response

## Operation
- FSM states: IDLE (no owner; HTRANS driven IDLE, other bus outputs 0), OWN0, OWN1. Current state defines the address owner. The address mux selects the owner's signals.
- Data owner register holds NONE, 0, or 1. On each HREADY=1 edge it loads the address owner if bus HTRANS ∈ {NONSEQ, SEQ}, else NONE.
- HWDATA is taken from the data owner, or 0 if NONE.
- mN_hrdata/mN_hresp always carry HRDATA/HRESP. Only the data owner's values are meaningful.
- mN_hready = HREADY if N is the data owner or the address owner. Otherwise it is 0 while mN_htrans ≠ IDLE, else 1.
- Handover is evaluated only at edges with HREADY=1. It is permitted when any of these holds:
  - state IDLE;
  - owner's hbusreq=0 and owner's htrans ∈ {IDLE, NONSEQ} and hlock=0;
  - beat count ≥ MAX_BEATS and the other master requests and owner's htrans ∈ {IDLE, NONSEQ} and hlock=0.
- SEQ/BUSY (mid-burst) or hlock=1 always blocks handover.
- Selection when handover is permitted: round-robin between requesters. The rr pointer names the preferred master and flips to the non-winner on each grant. If the owner still requests and the other does not, the owner keeps the grant. If no one requests, go to IDLE.
- Beat counter: increments on each accepted NONSEQ/SEQ by the owner (HREADY=1), saturates at MAX_BEATS, and clears on any ownership change.
- Master obligation: drive IDLE whenever mN_hgrant=0.
- HRESP ERROR is routed unchanged. The arbiter takes no action on it.

## Timing
- Reset values: state IDLE; mN_hgrant=0; HTRANS=IDLE; HADDR/HWDATA/controls/HMASTLOCK=0; data owner NONE; rr pointer=M0; beat count=0.
- Grant latency: a request seen at an HREADY=1 edge while handover is permitted gives mN_hgrant=1 after that edge. The first address is accepted at the next HREADY=1 edge. Minimum request-to-bus latency is 1 cycle.
- Ownership changes only on HREADY=1 edges. HREADY=0 freezes state, data owner, counter, and grants.
- A NONSEQ accepted at the handover edge completes its data phase under the old master while the new owner drives its address. Both see HREADY.
- Simultaneous requests from IDLE: the rr pointer decides (M0 after reset).
- Asynchronous reset mid-transfer immediately returns all outputs to reset values. In-flight transfers are abandoned.

## Test plan
- Reset, then M0 requests a single NONSEQ write to 0x100 → m0_hgrant=1 one cycle later; HADDR=0x100, HTRANS=NONSEQ; HWDATA = m0_hwdata in the data phase.
- Both request from IDLE → M0 granted first; after M0 drops hbusreq at IDLE, M1 granted; the next simultaneous contention goes to M0 again (round-robin).
- M0 runs INCR4 while M1 requests → no handover during SEQ beats; M1 granted on the edge after the 4th beat is accepted; m1_hready=0 while M1 waits driving NONSEQ.
- MAX_BEATS=4, M0 issues back-to-back singles with M1 requesting → handover after exactly 4 accepted beats, beat count cleared.
- M0 holds hlock=1 for 8 singles → HMASTLOCK=1 and no handover to M1 until hlock=0.
- HREADY held 0 for 3 wait states on M1's read with HRESP=ERROR → state frozen; M1 receives ERROR; an HRESETn pulse mid-burst forces HTRANS=IDLE and both grants 0 immediately.
